// File: rtl/mole_round_if.sv
// Handshake/data bundle between the game controller (master) and mole_round_sequencer (slave).
interface mole_round_if #(
  parameter int NUM_HOLES = 9,
  parameter int CNT_W     = 28,
  parameter int PTS_W     = 6
);
  logic                 start;
  logic [CNT_W-1:0]     light_between;
  logic [CNT_W-1:0]     light_on;
  logic [PTS_W-1:0]     total_points;
  logic [15:0]          rand_num;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic [NUM_HOLES-1:0] lights;
  logic [PTS_W-1:0]     score;
  logic [PTS_W-1:0]     misses;
  logic [PTS_W-1:0]     mole_count;
  logic                 busy;
  logic                 done;

  modport master (
    output start, light_between, light_on, total_points, rand_num, key_valid, key_code,
    input  lights, score, misses, mole_count, busy, done
  );

  modport slave (
    input  start, light_between, light_on, total_points, rand_num, key_valid, key_code,
    output lights, score, misses, mole_count, busy, done
  );
endinterface

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round sequencer: times each mole, picks its hole, keeps score/miss/mole counts.
// Optional macro WAM_DEATHMATCH_EN: a timeout or wrong key ends the game immediately.
module mole_round_sequencer #(
  parameter int NUM_HOLES = 9,
  parameter int CNT_W     = 28,
  parameter int PTS_W     = 6
) (
  input logic         CLOCK_50,
  input logic         reset,
  mole_round_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LIT, S_NEXT, S_DONE} state_t;

  localparam logic [3:0] NO_HOLE = 4'hF;

  state_t               r_state, w_state_n;
  logic [CNT_W-1:0]     r_timer, w_timer_n;
  logic [CNT_W-1:0]     r_between, w_between_n;
  logic [CNT_W-1:0]     r_on, w_on_n;
  logic [PTS_W-1:0]     r_total, w_total_n;
  logic [PTS_W-1:0]     r_score, w_score_n;
  logic [PTS_W-1:0]     r_misses, w_misses_n;
  logic [PTS_W-1:0]     r_moles, w_moles_n;
  logic [3:0]           r_last, w_last_n;
  logic [3:0]           w_pick;
  logic [NUM_HOLES-1:0] r_lights, w_lights_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;
  logic                 w_hit;
  logic                 w_timeout;
  logic                 w_unused_rand;

  // Fold the 4-bit random value into 0..8, then step past a repeat of the previous hole.
  function automatic logic [3:0] f_pick_hole(input logic [3:0] r, input logic [3:0] last);
    logic [3:0] h0;
    h0 = (r >= 4'd9) ? (r - 4'd9) : r;
    if (h0 == last) return (h0 == 4'd8) ? 4'd0 : (h0 + 4'd1);
    return h0;
  endfunction

  assign w_unused_rand = ^bus.rand_num[15:4];
  assign w_pick        = f_pick_hole(bus.rand_num[3:0], r_last);
  assign w_hit         = bus.key_valid && (bus.key_code == r_last);
  assign w_timeout     = (r_timer == r_on);

  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_between_n = r_between;
    w_on_n      = r_on;
    w_total_n   = r_total;
    w_score_n   = r_score;
    w_misses_n  = r_misses;
    w_moles_n   = r_moles;
    w_last_n    = r_last;
    w_lights_n  = r_lights;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_lights_n = '0;
        if (bus.start) begin
          w_between_n = bus.light_between;
          w_on_n      = bus.light_on;
          w_total_n   = bus.total_points;
          w_score_n   = '0;
          w_misses_n  = '0;
          w_moles_n   = '0;
          w_timer_n   = '0;
          w_state_n   = (bus.total_points == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_timer == r_between) begin
          w_lights_n = NUM_HOLES'(1) << w_pick;
          w_last_n   = w_pick;
          w_timer_n  = '0;
          w_state_n  = S_LIT;
        end else begin
          w_timer_n = r_timer + CNT_W'(1);
        end
      end
      S_LIT: begin
        // A hit wins over a timeout landing in the same cycle.
        if (w_hit) begin
          w_score_n  = r_score + PTS_W'(1);
          w_lights_n = '0;
          w_state_n  = S_NEXT;
        end else if (w_timeout) begin
          w_misses_n = r_misses + PTS_W'(1);
          w_lights_n = '0;
`ifdef WAM_DEATHMATCH_EN
          w_state_n  = S_DONE;
`else
          w_state_n  = S_NEXT;
`endif
`ifdef WAM_DEATHMATCH_EN
        end else if (bus.key_valid) begin
          w_misses_n = r_misses + PTS_W'(1);
          w_lights_n = '0;
          w_state_n  = S_DONE;
`endif
        end else begin
          w_timer_n = r_timer + CNT_W'(1);
        end
      end
      S_NEXT: begin
        w_lights_n = '0;
        w_moles_n  = r_moles + PTS_W'(1);
        if ((r_moles + PTS_W'(1)) == r_total) begin
          w_state_n = S_DONE;
        end else begin
          w_timer_n = '0;
          w_state_n = S_WAIT;
        end
      end
      default: begin
        w_lights_n = '0;
        w_state_n  = S_IDLE;
      end
    endcase

    w_busy_n = (w_state_n == S_WAIT) || (w_state_n == S_LIT) || (w_state_n == S_NEXT);
    w_done_n = (w_state_n == S_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_moles  <= '0;
      r_last   <= NO_HOLE;
      r_lights <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_score  <= w_score_n;
      r_misses <= w_misses_n;
      r_moles  <= w_moles_n;
      r_last   <= w_last_n;
      r_lights <= w_lights_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
    end
  end

  // Game configuration is only meaningful after a start, so it carries no reset.
  always_ff @(posedge CLOCK_50) begin
    r_between <= w_between_n;
    r_on      <= w_on_n;
    r_total   <= w_total_n;
  end

  assign bus.lights     = r_lights;
  assign bus.score      = r_score;
  assign bus.misses     = r_misses;
  assign bus.mole_count = r_moles;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_mole_round_sequencer.sv
// Directed bench for mole_round_sequencer with a queue of expected hole patterns.
module tb_mole_round_sequencer;
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] sb[$];

  mole_round_if #(.NUM_HOLES(9), .CNT_W(28), .PTS_W(6)) bus ();

  mole_round_sequencer #(.NUM_HOLES(9), .CNT_W(28), .PTS_W(6)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int sc, input int mi, input int mo,
                            input int bz, input int dn);
    chk({tag, "_score"},  32'(bus.score),      32'(sc));
    chk({tag, "_misses"}, 32'(bus.misses),     32'(mi));
    chk({tag, "_moles"},  32'(bus.mole_count), 32'(mo));
    chk({tag, "_busy"},   32'(bus.busy),       32'(bz));
    chk({tag, "_done"},   32'(bus.done),       32'(dn));
    chk({tag, "_lights"}, 32'(bus.lights),     32'(0));
  endtask

  task automatic start_game(input logic [27:0] lb, input logic [27:0] lo, input logic [5:0] tp);
    bus.light_between = lb;
    bus.light_on      = lo;
    bus.total_points  = tp;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
  endtask

  task automatic wait_rise(input int exp_n, input string tag);
    int n = 0;
    logic [8:0] exp_l;
    while (bus.lights == 9'd0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_delay"}, 32'(n), 32'(exp_n));
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed lights %0h with no expected pattern queued", tag, bus.lights);
    end
    if (sb.size() > 0) begin
      exp_l = sb.pop_front();
      chk({tag, "_hole"}, 32'(bus.lights), 32'(exp_l));
    end
  endtask

  task automatic wait_fall(input int exp_n, input string tag);
    int n = 0;
    while (bus.lights != 9'd0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lit"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.light_between = '0;
    bus.light_on      = '0;
    bus.total_points  = '0;
    bus.rand_num      = '0;
    bus.key_valid     = 1'b0;
    bus.key_code      = '0;
    reset = 1'b1;
    tick();
    tick();
    chk_counts("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Reset while a mole is lit
    bus.rand_num = 16'h000D;
    sb.push_back(9'h010);
    start_game(28'd3, 28'd5, 6'd2);
    chk("A_busy", 32'(bus.busy), 32'(1));
    wait_rise(4, "A_rise");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_counts("A_rst", 0, 0, 0, 0, 0);

    // No keys: every mole times out; repeat of 13 steps to hole 5
    bus.rand_num = 16'h000D;
    sb.push_back(9'h010);
    start_game(28'd3, 28'd5, 6'd2);
    wait_rise(4, "B_rise1");
    wait_fall(6, "B_m1");
    chk("B_m1_misses", 32'(bus.misses), 32'(1));
`ifdef WAM_DEATHMATCH_EN
    chk_counts("B_end", 0, 1, 0, 0, 1);
`else
    sb.push_back(9'h020);
    chk("B_m1_moles_pre", 32'(bus.mole_count), 32'(0));
    tick();
    chk("B_m1_moles", 32'(bus.mole_count), 32'(1));
    wait_rise(4, "B_rise2");
    wait_fall(6, "B_m2");
    tick();
    chk_counts("B_end", 0, 2, 2, 0, 1);
`endif

    // Hits: first LIT cycle, then coincident with timeout
    bus.rand_num = 16'h0002;
    sb.push_back(9'h004);
    start_game(28'd2, 28'd4, 6'd2);
    chk_counts("C_clr", 0, 0, 0, 1, 0);
    wait_rise(3, "C_rise1");
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd2;
    tick();
    bus.key_valid = 1'b0;
    chk("C_hit1_score",  32'(bus.score),  32'(1));
    chk("C_hit1_lights", 32'(bus.lights), 32'(0));
    tick();
    chk("C_hit1_moles", 32'(bus.mole_count), 32'(1));
    bus.rand_num = 16'h0008;
    sb.push_back(9'h100);
    wait_rise(3, "C_rise2");
    repeat (4) tick();
    chk("C_m2_still_lit", 32'(bus.lights), 32'(9'h100));
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd8;
    tick();
    bus.key_valid = 1'b0;
    chk("C_coinc_score",  32'(bus.score),  32'(2));
    chk("C_coinc_misses", 32'(bus.misses), 32'(0));
    tick();
    chk_counts("C_end", 2, 0, 2, 0, 1);

    // Wrong keys; inputs changed while busy; repeat of 8 wraps to hole 0
    bus.rand_num = 16'h0001;
    sb.push_back(9'h002);
    start_game(28'd1, 28'd3, 6'd3);
    bus.light_between = 28'd50;
    bus.light_on      = 28'd50;
    bus.total_points  = 6'd1;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
    wait_rise(1, "D_rise1");
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd3;
    tick();
`ifdef WAM_DEATHMATCH_EN
    bus.key_valid = 1'b0;
    chk_counts("D_dm", 0, 1, 0, 0, 1);
`else
    chk("D_wrong3_lights", 32'(bus.lights), 32'(9'h002));
    chk("D_wrong3_misses", 32'(bus.misses), 32'(0));
    bus.key_code = 4'd15;
    tick();
    bus.key_valid = 1'b0;
    chk("D_wrong15_lights", 32'(bus.lights), 32'(9'h002));
    wait_fall(2, "D_m1");
    chk("D_m1_misses", 32'(bus.misses), 32'(1));
    tick();
    chk("D_m1_moles", 32'(bus.mole_count), 32'(1));
    bus.rand_num = 16'h0008;
    sb.push_back(9'h100);
    wait_rise(2, "D_rise2");
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd8;
    tick();
    bus.key_valid = 1'b0;
    chk("D_hit2_score", 32'(bus.score), 32'(1));
    tick();
    sb.push_back(9'h001);
    wait_rise(2, "D_rise3");
    wait_fall(4, "D_m3");
    tick();
    chk_counts("D_end", 1, 2, 3, 0, 1);
`endif

    // Zero-length game from DONE
    start_game(28'd1, 28'd3, 6'd0);
    chk_counts("E_zero", 0, 0, 0, 0, 1);
    repeat (5) tick();
    chk("E_dark",      32'(bus.lights), 32'(0));
    chk("E_done_hold", 32'(bus.done),   32'(1));
    chk("sb_drained",  32'(sb.size()),  32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
